// File: rtl/illegal_instruction_exception_unit_if.sv
// Decode-side and exception-side signals of the illegal-instruction exception unit.
// The unit itself connects through the slave modport; the driving environment uses master.
interface illegal_instruction_exception_unit_if #(
  parameter int unsigned ID_W    = 3,
  parameter int unsigned COUNT_W = 16
);
  logic               decode_valid;
  logic [31:0]        decode_pc;
  logic [31:0]        decode_instruction;
  logic [ID_W-1:0]    decode_id;
  logic               illegal_instruction;
  logic               pipeline_idle;
  logic               flush;
  logic               decode_stall;
  logic               exception_valid;
  logic [4:0]         exception_code;
  logic [31:0]        exception_pc;
  logic [31:0]        exception_tval;
  logic [ID_W-1:0]    exception_id;
  logic               exception_ack;
  logic [COUNT_W-1:0] illegal_count;

  modport slave (
    input  decode_valid, decode_pc, decode_instruction, decode_id, illegal_instruction,
    input  pipeline_idle, flush, exception_ack,
    output decode_stall, exception_valid, exception_code, exception_pc, exception_tval,
    output exception_id, illegal_count
  );

  modport master (
    output decode_valid, decode_pc, decode_instruction, decode_id, illegal_instruction,
    output pipeline_idle, flush, exception_ack,
    input  decode_stall, exception_valid, exception_code, exception_pc, exception_tval,
    input  exception_id, illegal_count
  );
endinterface

// File: rtl/illegal_instruction_exception_unit.sv
// Illegal-instruction exception unit: stalls decode on a flagged instruction, captures its
// PC/encoding/ID, waits for older instructions to drain, then raises an mcause-2 request
// that is held until acknowledged. Counts acknowledged exceptions (saturating).
module illegal_instruction_exception_unit #(
  parameter int unsigned ID_W          = 3,
  parameter bit          TVAL_ENCODING = 1'b1,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  illegal_instruction_exception_unit_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDrain   = 2'd1,
    StRequest = 2'd2
  } state_e;

  localparam logic [4:0] IllegalCause = 5'd2;

  state_e             state_q, state_d;
  logic [31:0]        cap_pc_q, cap_pc_d;
  logic [31:0]        cap_tval_q, cap_tval_d;
  logic [ID_W-1:0]    cap_id_q, cap_id_d;
  logic               exc_valid_q, exc_valid_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [31:0]        exc_pc_q, exc_pc_d;
  logic [31:0]        exc_tval_q, exc_tval_d;
  logic [ID_W-1:0]    exc_id_q, exc_id_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               illegal_accept;

  // A flagged instruction is taken only if no flush is discarding it this cycle.
  assign illegal_accept = bus.decode_valid & bus.illegal_instruction & ~bus.flush;

  // Combinational stall so the illegal instruction never issues, even in its first cycle.
  assign bus.decode_stall = (state_q != StIdle) | illegal_accept;

  assign bus.exception_valid = exc_valid_q;
  assign bus.exception_code  = exc_code_q;
  assign bus.exception_pc    = exc_pc_q;
  assign bus.exception_tval  = exc_tval_q;
  assign bus.exception_id    = exc_id_q;
  assign bus.illegal_count   = count_q;

  // Next-state and registered-output logic for the capture/drain/request sequence.
  always_comb begin
    state_d     = state_q;
    cap_pc_d    = cap_pc_q;
    cap_tval_d  = cap_tval_q;
    cap_id_d    = cap_id_q;
    exc_valid_d = exc_valid_q;
    exc_code_d  = exc_code_q;
    exc_pc_d    = exc_pc_q;
    exc_tval_d  = exc_tval_q;
    exc_id_d    = exc_id_q;
    count_d     = count_q;
    unique case (state_q)
      StIdle: begin
        if (illegal_accept) begin
          cap_pc_d   = bus.decode_pc;
          cap_tval_d = TVAL_ENCODING ? bus.decode_instruction : 32'd0;
          cap_id_d   = bus.decode_id;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        // Flush wins over drain completion.
        if (bus.flush) begin
          state_d = StIdle;
        end else if (bus.pipeline_idle) begin
          state_d     = StRequest;
          exc_valid_d = 1'b1;
          exc_code_d  = IllegalCause;
          exc_pc_d    = cap_pc_q;
          exc_tval_d  = cap_tval_q;
          exc_id_d    = cap_id_q;
        end
      end
      StRequest: begin
        // Request is committed: flush is ignored, only ack releases it.
        if (bus.exception_ack) begin
          state_d     = StIdle;
          exc_valid_d = 1'b0;
          exc_code_d  = 5'd0;
          exc_pc_d    = 32'd0;
          exc_tval_d  = 32'd0;
          exc_id_d    = '0;
          if (count_q != {COUNT_W{1'b1}}) begin
            count_d = count_q + COUNT_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any capture immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cap_pc_q    <= 32'd0;
      cap_tval_q  <= 32'd0;
      cap_id_q    <= '0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= 5'd0;
      exc_pc_q    <= 32'd0;
      exc_tval_q  <= 32'd0;
      exc_id_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cap_pc_q    <= cap_pc_d;
      cap_tval_q  <= cap_tval_d;
      cap_id_q    <= cap_id_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
      exc_pc_q    <= exc_pc_d;
      exc_tval_q  <= exc_tval_d;
      exc_id_q    <= exc_id_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_illegal_instruction_exception_unit.sv
// Self-checking bench: two instances (default parameters, and TVAL_ENCODING=0 / COUNT_W=2)
// driven with identical stimulus and compared every cycle against a behavioural model.
module tb_illegal_instruction_exception_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int failures = 0;

  illegal_instruction_exception_unit_if #(.ID_W(3), .COUNT_W(16)) bus1 ();
  illegal_instruction_exception_unit_if #(.ID_W(3), .COUNT_W(2))  bus2 ();

  illegal_instruction_exception_unit #(
    .ID_W(3), .TVAL_ENCODING(1'b1), .COUNT_W(16)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  illegal_instruction_exception_unit #(
    .ID_W(3), .TVAL_ENCODING(1'b0), .COUNT_W(2)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  // Behavioural model: an instruction is either absent, captured and waiting, or requested.
  bit          m_captured;
  bit          m_requested;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [2:0]  m_id;
  int          m_acked;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit dv, input bit ill, input logic [31:0] pc,
                       input logic [31:0] instr, input logic [2:0] id, input bit idle,
                       input bit fl, input bit ack);
    bus1.decode_valid = dv;        bus2.decode_valid = dv;
    bus1.illegal_instruction = ill; bus2.illegal_instruction = ill;
    bus1.decode_pc = pc;           bus2.decode_pc = pc;
    bus1.decode_instruction = instr; bus2.decode_instruction = instr;
    bus1.decode_id = id;           bus2.decode_id = id;
    bus1.pipeline_idle = idle;     bus2.pipeline_idle = idle;
    bus1.flush = fl;               bus2.flush = fl;
    bus1.exception_ack = ack;      bus2.exception_ack = ack;
  endtask

  task automatic model_reset();
    m_captured = 0; m_requested = 0; m_pc = '0; m_instr = '0; m_id = '0; m_acked = 0;
  endtask

  task automatic check_outputs(input bit exp_stall);
    int sat2;
    sat2 = (m_acked > 3) ? 3 : m_acked;
    check("stall", bus1.decode_stall, exp_stall);
    check("valid", bus1.exception_valid, m_requested);
    check("code", bus1.exception_code, m_requested ? 32'd2 : 32'd0);
    check("count", bus1.illegal_count, m_acked);
    if (m_requested) begin
      check("pc", bus1.exception_pc, m_pc);
      check("tval", bus1.exception_tval, m_instr);
      check("id", bus1.exception_id, m_id);
      check("tval0", bus2.exception_tval, 32'd0);
      check("pc2", bus2.exception_pc, m_pc);
    end
    check("stall2", bus2.decode_stall, exp_stall);
    check("valid2", bus2.exception_valid, m_requested);
    check("count2", bus2.illegal_count, sat2);
  endtask

  // One clock cycle: drive, check against model, clock edge, advance model.
  task automatic cyc(input bit dv, input bit ill, input logic [31:0] pc,
                     input logic [31:0] instr, input logic [2:0] id, input bit idle,
                     input bit fl, input bit ack);
    drive(dv, ill, pc, instr, id, idle, fl, ack);
    #1;
    check_outputs(m_captured || (dv && ill && !fl));
    @(posedge clk);
    if (m_requested) begin
      if (ack) begin
        m_requested = 0;
        m_captured = 0;
        if (m_acked < 65535) m_acked++;
      end
    end else if (m_captured) begin
      if (fl) m_captured = 0;
      else if (idle) m_requested = 1;
    end else if (dv && ill && !fl) begin
      m_captured = 1; m_pc = pc; m_instr = instr; m_id = id;
    end
    #1;
  endtask

  task automatic idle_cyc(input bit idle, input bit fl, input bit ack);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, idle, fl, ack);
  endtask

  initial begin
    model_reset();
    drive(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 0);
    #12;
    check_outputs(1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Minimum latency, ack two cycles after the request appears.
    cyc(1, 1, 32'h8000_0010, 32'hFFFF_FFFF, 3'd5, 1, 0, 0);
    idle_cyc(1, 0, 0);
    idle_cyc(1, 0, 0);
    idle_cyc(1, 0, 0);
    idle_cyc(1, 0, 1);
    idle_cyc(1, 0, 0);

    // Long drain: pipeline busy for six cycles; decode encoding changes are ignored.
    cyc(1, 1, 32'h0000_1000, 32'h0000_707F, 3'd2, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 32'hDEAD_0000, 32'h1234_5678, 3'd7, 0, 0, 1);
    idle_cyc(1, 0, 0);
    idle_cyc(0, 0, 0);
    idle_cyc(0, 0, 1);

    // Flush during drain discards; flush with illegal in idle is ignored.
    cyc(1, 1, 32'h0000_2000, 32'h0000_0000, 3'd1, 0, 0, 0);
    idle_cyc(0, 1, 0);
    idle_cyc(1, 0, 1);
    cyc(1, 1, 32'h0000_3000, 32'h0000_0001, 3'd3, 1, 1, 0);
    idle_cyc(1, 0, 0);

    // Flush during request is ignored.
    cyc(1, 1, 32'h0000_4000, 32'hABCD_EF01, 3'd4, 1, 0, 0);
    idle_cyc(1, 0, 0);
    idle_cyc(1, 1, 0);
    idle_cyc(1, 1, 1);

    // Back-to-back: second illegal waits at decode through the ack of the first.
    cyc(1, 1, 32'h0000_0010, 32'h0000_0013, 3'd6, 1, 0, 0);
    idle_cyc(1, 0, 0);
    cyc(1, 1, 32'h0000_0020, 32'h0000_0033, 3'd1, 1, 0, 0);
    cyc(1, 1, 32'h0000_0020, 32'h0000_0033, 3'd1, 1, 0, 1);
    cyc(1, 1, 32'h0000_0020, 32'h0000_0033, 3'd1, 1, 0, 0);
    idle_cyc(1, 0, 0);
    idle_cyc(1, 0, 0);
    idle_cyc(1, 0, 1);
    idle_cyc(1, 0, 0);

    // Reset asserted mid-request drops the request asynchronously.
    cyc(1, 1, 32'h0000_5000, 32'h0000_0FFF, 3'd2, 1, 0, 0);
    idle_cyc(1, 0, 0);
    drive(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 0);
    check("pre_rst_valid", bus1.exception_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), $urandom(), $urandom(),
          3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 1),
          ($urandom_range(0, 9) < 4));
    end
    idle_cyc(1, 0, 1);
    idle_cyc(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/illegal_instruction_exception_unit.md
Name: illegal_instruction_exception_unit

Overview:
- Decode-side consumer of the illegal-instruction flag produced for each decoded instruction.
- When a decoded instruction is flagged illegal, the unit stalls decode and captures the PC, encoding and ID. It waits for older in-flight instructions to drain, then presents an illegal-instruction exception request (mcause 2) to the gc/exception logic.
- It holds the request until the exception logic acknowledges it.

Parameters:
- ID_W, 3, width of the instruction ID tag.
- TVAL_ENCODING, 1, 1: exception_tval = faulting encoding; 0: exception_tval = 0.
- COUNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- decode_valid  in  1  decode stage holds a valid instruction
- decode_pc  in  32  PC of decode instruction
- decode_instruction  in  32  encoding of decode instruction
- decode_id  in  ID_W  ID of decode instruction
- illegal_instruction  in  1  checker result for decode_instruction; qualified by decode_valid
- pipeline_idle  in  1  no older instructions outstanding past issue
- flush  in  1  gc flush (mispredict or earlier exception); discards a pending capture
- decode_stall  out  1  hold decode; do not issue
- exception_valid  out  1  exception request
- exception_code  out  5  constant 5'd2 while exception_valid, else 0
- exception_pc  out  32  captured PC
- exception_tval  out  32  captured encoding or 0, per TVAL_ENCODING
- exception_id  out  ID_W  captured ID
- exception_ack  in  1  exception logic accepted the request
- illegal_count  out  COUNT_W  number of acknowledged illegal exceptions, saturating

Behaviour:
- States: IDLE, DRAIN, REQUEST. Two-bit state register.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - exception_valid = 0; exception_code, exception_pc, exception_tval, exception_id = 0.
  - illegal_count = 0.
  - decode_stall is combinational and is therefore 0 under reset while inputs are idle.
  - Reset mid-operation abandons any capture immediately; no request survives reset.
- decode_stall = (state != IDLE) | (decode_valid & illegal_instruction & ~flush). The stall is combinational so the illegal instruction never issues, including in its first cycle.
- IDLE:
  - On decode_valid & illegal_instruction & ~flush: capture pc, encoding and id into internal registers. Next state is DRAIN.
  - decode_valid & illegal_instruction & flush: ignored, stay IDLE.
- DRAIN:
  - flush = 1: discard the capture, go to IDLE next cycle; flush takes priority over pipeline_idle.
  - Else, pipeline_idle = 1: go to REQUEST.
  - Else stay in DRAIN. No timeout.
- REQUEST:
  - exception_valid = 1 registered, asserted on the first REQUEST cycle, i.e. the cycle after pipeline_idle was sampled high.
  - exception_code = 2; exception_pc, exception_tval and exception_id driven from the capture registers; all are stable while valid.
  - flush is ignored: the request is committed.
  - On exception_ack: go to IDLE; exception_valid = 0 next cycle; illegal_count += 1, saturating at all-ones.
  - The ack is sampled only while exception_valid = 1. An ack in IDLE or DRAIN has no effect.
- Minimum latency: illegal flagged in cycle N with pipeline_idle already 1 → DRAIN in N+1 → exception_valid high in N+2.
- Back-to-back: in the ack cycle decode_stall is still 1. A new illegal instruction at decode is captured on the first IDLE cycle after the ack, giving at least one bubble between requests.
- Captured fields are not updated outside IDLE; decode_instruction changes during DRAIN/REQUEST do not alter the outputs.
- illegal_count increments only on ack, never on flush-discarded captures.

Test Plan:
- Reset then idle inputs → all outputs 0, decode_stall = 0; assert rst_n low mid-REQUEST → exception_valid drops asynchronously, state IDLE.
- Illegal at N (pc=0x80000010, instr=0xFFFFFFFF, id=5), pipeline_idle = 1 → decode_stall=1 at N; exception_valid=1 at N+2 with code=2, pc=0x80000010, tval=0xFFFFFFFF, id=5; ack at N+4 → valid=0 at N+5, illegal_count=1.
- Illegal with pipeline_idle = 0 for 6 cycles → DRAIN held, exception_valid stays 0; valid asserts the cycle after pipeline_idle rises.
- Flush in DRAIN → state IDLE, no request, illegal_count unchanged. Flush in REQUEST → request held until ack. Flush in the same cycle as illegal in IDLE → no capture, decode_stall=0.
- TVAL_ENCODING=0, instr=0x0000707F → exception_tval = 0. COUNT_W=2, five acked exceptions → illegal_count = 3.
- Second illegal (pc=0x20) present at decode during ack of the first → second captured one cycle after ack; exception_pc = 0x20 on the next request; the first request's fields are unchanged until its ack.
